// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared state encoding and default payload width for the 4-way dispatcher
package dispatch_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin destination pick from ptr, preferring enabled-and-ready over merely enabled
module rr_pick4
    import dispatch_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic [3:0] en,
    input  logic [3:0] dstRdy,
    output logic [1:0] sel
);

    logic [1:0] idx;
    logic [1:0] selRdy;
    logic [1:0] selEn;
    logic       hitRdy;

    // Scanning from the far end leaves the candidate closest to ptr as the final assignment.
    always_comb begin
        idx    = ptr;
        selRdy = ptr;
        selEn  = ptr;
        hitRdy = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (en[idx] && dstRdy[idx]) begin
                selRdy = idx;
                hitRdy = 1'b1;
            end
            if (en[idx]) begin
                selEn = idx;
            end
        end
        sel = hitRdy ? selRdy : selEn;
    end

endmodule

// File: rtl/demux4_dispatch.sv
// rtl/demux4_dispatch.sv - single-token buffer routing each payload to one of four destinations
module demux4_dispatch
    import dispatch_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InVld,
    input  logic [DW-1:0] InData,
    output logic          InRdy,
    input  logic [3:0]    En,
    input  logic [3:0]    DstRdy,
    output logic [3:0]    OutVld,
    output logic [DW-1:0] OutData,
    output logic [1:0]    S,
    output logic          Busy,
    output logic [7:0]    XferCnt
);

    state_t        state;
    state_t        stateNext;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic [1:0]    pick;
    logic [DW-1:0] buffer;
    logic          accept;
    logic          handshake;

    rr_pick4 uPick (
        .ptr    (ptr),
        .en     (En),
        .dstRdy (DstRdy),
        .sel    (pick)
    );

    always_comb begin
        stateNext = state;
        InRdy     = 1'b0;
        accept    = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                InRdy  = (En != 4'b0000);
                accept = InVld & InRdy;
                if (accept) stateNext = ROUTE;
            end
            ROUTE: begin
                handshake = DstRdy[sel];
                if (handshake) stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // sel is frozen at acceptance so later En/DstRdy changes cannot redirect a held token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 2'd0;
            sel     <= 2'd0;
            buffer  <= '0;
            XferCnt <= 8'd0;
        end else begin
            if (accept) begin
                buffer <= InData;
                sel    <= pick;
            end
            if (handshake) begin
                ptr     <= sel + 2'd1;
                XferCnt <= XferCnt + 8'd1;
            end
        end
    end

    assign OutVld  = (state == ROUTE) ? (4'b0001 << sel) : 4'b0000;
    assign OutData = buffer;
    assign S       = sel;
    assign Busy    = (state == ROUTE);

endmodule

// File: doc/demux4_dispatch.md
DEMUX4_DISPATCH -- requirements
Module: demux4_dispatch

Interface
REQ-001 Parameter DW, default 16, sets the payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 InVld  input  1  upstream token valid.
REQ-005 InData  input  DW  upstream payload.
REQ-006 InRdy  output  1  block can accept a token this cycle.
REQ-007 En  input  4  per-destination enable mask; bit k=1 means destination k is eligible.
REQ-008 DstRdy  input  4  per-destination ready.
REQ-009 OutVld  output  4  one-hot valid to destination k, or all-zero.
REQ-010 OutData  output  DW  held payload, common to all destinations.
REQ-011 S  output  2  index of the committed destination.
REQ-012 Busy  output  1  high while a token is held.
REQ-013 XferCnt  output  8  count of completed transfers.

Function
REQ-014 The block SHALL implement two states:
- IDLE: buffer empty.
- ROUTE: one token held.
REQ-015 In IDLE, InRdy SHALL equal (En != 4'b0000); in ROUTE, InRdy SHALL be 0.
REQ-016 Acceptance:
- Occurs when InVld & InRdy in IDLE.
- SHALL capture InData into the buffer.
- SHALL commit the destination sel.
- SHALL enter ROUTE on the next edge.
REQ-017 Selection:
- sel SHALL be the first index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4) with En[k] & DstRdy[k] = 1.
- If none qualifies, sel SHALL be the first index in that order with En[k] = 1.
REQ-018 In ROUTE, S SHALL equal sel and OutVld SHALL be one-hot at bit sel; in IDLE, OutVld SHALL be 4'b0000.
REQ-019 Once committed, sel and OutData SHALL stay stable until the handshake, even if En[sel] or DstRdy changes.
REQ-020 Handshake:
- Completes in any ROUTE cycle with DstRdy[sel] = 1.
- On that edge: state to IDLE, ptr to (sel+1) mod 4, XferCnt to XferCnt+1.
REQ-021 XferCnt SHALL wrap from 255 to 0 with no flag.
REQ-022 Minimum latency: OutVld SHALL assert 1 cycle after acceptance; sustained throughput SHALL be one token per 2 cycles.
REQ-023 With En = 4'b0000 in IDLE, InRdy SHALL be 0 and InVld SHALL be ignored.
REQ-024 Busy SHALL be 1 exactly in ROUTE.
REQ-025 DstRdy bits of unselected destinations SHALL have no effect in ROUTE.

Reset
REQ-026 On rst assertion, the block SHALL immediately set:
- state = IDLE, ptr = 0, XferCnt = 0, buffer = 0.
- OutVld = 0, S = 0, Busy = 0, OutData = 0.
REQ-027 InRdy SHALL follow REQ-015 from IDLE during and after reset.
REQ-028 A token held when rst asserts SHALL be discarded and SHALL not be counted.
REQ-029 The first acceptance after rst deassertion SHALL scan from index 0.

Structure
REQ-030 State encodings (IDLE, ROUTE) and the default DW SHALL live in a shared package dispatch_pkg.
REQ-031 The round-robin scan (ptr, En, DstRdy -> sel) SHALL be a combinational sub-module rr_pick4.
REQ-032 The one-hot OutVld decode SHALL be a pure function of state and sel, with no extra register stage.

Verification
REQ-033 Basic routing: En=1111, DstRdy=1111, four back-to-back tokens 0xA000..0xA003 -> OutVld 0001, 0010, 0100, 1000 in order; XferCnt=4; gaps of one cycle.
REQ-034 Skip not-ready: ptr=0, DstRdy=0100, En=1111, token 0x1234 -> S=2, OutVld=0100 one cycle later; next ptr=3.
REQ-035 Stall and hold: En=0010, DstRdy=0000, token 0x55AA -> OutVld=0010 held stable with OutData=0x55AA for 10 cycles; then DstRdy=0010 -> IDLE next edge, XferCnt+1.
REQ-036 Disabled mask: En=0000, InVld=1 for 5 cycles -> InRdy=0, OutVld=0000, XferCnt unchanged.
REQ-037 Reset mid-ROUTE: assert rst while OutVld=0100 -> OutVld=0000, Busy=0, XferCnt=0 without waiting for clk; next token routes to destination 0.
REQ-038 Counter wrap: 256 completed transfers -> XferCnt returns to 0x00.
